// File: rtl/plot_arb_pkg.sv
// Shared types and screen constants for the plot arbiter.
package plot_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SERVE = 2'd2
  } state_t;

  localparam int NUM_REQ_DEF  = 4;
  localparam int X_W_DEF      = 8;
  localparam int Y_W_DEF      = 7;
  localparam int COLOUR_W_DEF = 3;
  localparam int X_MAX_DEF    = 159;
  localparam int Y_MAX_DEF    = 119;
  localparam logic [COLOUR_W_DEF-1:0] BG_COLOUR_DEF = 3'b000;
  localparam int STAT_W       = 16;

endpackage

// File: rtl/plot_arbiter_rr_arbiter.sv
// Round-robin grant: first valid index at or after ptr, wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [PTR_W-1:0]   ptr,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   next_ptr
);

  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    grant    = '0;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = PTR_W'((int'(ptr) + k) % NUM_REQ);
      if (advance && !found && valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        next_ptr   = PTR_W'((int'(idx) + 1) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/plot_arbiter.sv
// Shares the vga_adapter plot port: per-frame background sweep, then round-robin sprite pixels.
// Define PLOT_ARBITER_STATS_EN to add drop_count / overrun_count saturating counters.
//
// state | meaning
// IDLE  | waiting for the first frame_tick, no plotting
// CLEAR | sweeping every pixel to BG_COLOUR, one per cycle
// SERVE | granting requester pixels round-robin until the next frame_tick
module plot_arbiter
  import plot_arb_pkg::*;
#(
  parameter int NUM_REQ  = NUM_REQ_DEF,
  parameter int X_W      = X_W_DEF,
  parameter int Y_W      = Y_W_DEF,
  parameter int COLOUR_W = COLOUR_W_DEF,
  parameter int X_MAX    = X_MAX_DEF,
  parameter int Y_MAX    = Y_MAX_DEF,
  parameter logic [COLOUR_W-1:0] BG_COLOUR = BG_COLOUR_DEF
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         frame_tick,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*X_W-1:0]       req_x,
  input  logic [NUM_REQ*Y_W-1:0]       req_y,
  input  logic [NUM_REQ*COLOUR_W-1:0]  req_colour,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [X_W-1:0]               x,
  output logic [Y_W-1:0]               y,
  output logic [COLOUR_W-1:0]          colour,
  output logic                         plot,
  output logic                         busy
`ifdef PLOT_ARBITER_STATS_EN
  ,
  output logic [STAT_W-1:0]            drop_count,
  output logic [STAT_W-1:0]            overrun_count
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t               state_q, state_d;
  logic [X_W-1:0]       sweep_x_q, sweep_x_d;
  logic [Y_W-1:0]       sweep_y_q, sweep_y_d;
  logic [X_W-1:0]       x_d;
  logic [Y_W-1:0]       y_d;
  logic [COLOUR_W-1:0]  colour_d;
  logic                 plot_d;
  logic [PTR_W-1:0]     ptr_q, ptr_next;
  logic [NUM_REQ-1:0]   grant;
  logic                 grant_en, transfer, in_range;
  logic [X_W-1:0]       sel_x;
  logic [Y_W-1:0]       sel_y;
  logic [COLOUR_W-1:0]  sel_colour;

  // The tick cycle in SERVE issues no grant so the pointer cannot move under a frame restart.
  assign grant_en = (state_q == SERVE) && !frame_tick;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .valid    (req_valid),
    .ptr      (ptr_q),
    .advance  (grant_en),
    .grant    (grant),
    .next_ptr (ptr_next)
  );

  assign req_ready = grant;
  assign transfer  = |grant;
  assign busy      = (state_q == CLEAR);

  always_comb begin
    sel_x      = '0;
    sel_y      = '0;
    sel_colour = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_x      = req_x[i*X_W +: X_W];
        sel_y      = req_y[i*Y_W +: Y_W];
        sel_colour = req_colour[i*COLOUR_W +: COLOUR_W];
      end
    end
  end

  assign in_range = (sel_x <= X_W'(X_MAX)) && (sel_y <= Y_W'(Y_MAX));

  always_comb begin
    state_d   = state_q;
    sweep_x_d = sweep_x_q;
    sweep_y_d = sweep_y_q;
    x_d       = x;
    y_d       = y;
    colour_d  = colour;
    plot_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_tick) begin
          state_d   = CLEAR;
          sweep_x_d = '0;
          sweep_y_d = '0;
        end
      end
      CLEAR: begin
        x_d      = sweep_x_q;
        y_d      = sweep_y_q;
        colour_d = BG_COLOUR;
        plot_d   = 1'b1;
        if (sweep_x_q == X_W'(X_MAX)) begin
          sweep_x_d = '0;
          if (sweep_y_q == Y_W'(Y_MAX)) begin
            sweep_y_d = '0;
            state_d   = SERVE;
          end else begin
            sweep_y_d = sweep_y_q + 1'b1;
          end
        end else begin
          sweep_x_d = sweep_x_q + 1'b1;
        end
      end
      SERVE: begin
        if (frame_tick) begin
          state_d   = CLEAR;
          sweep_x_d = '0;
          sweep_y_d = '0;
        end else if (transfer && in_range) begin
          x_d      = sel_x;
          y_d      = sel_y;
          colour_d = sel_colour;
          plot_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      sweep_x_q <= '0;
      sweep_y_q <= '0;
      ptr_q     <= '0;
      x         <= '0;
      y         <= '0;
      colour    <= '0;
      plot      <= 1'b0;
    end else begin
      state_q   <= state_d;
      sweep_x_q <= sweep_x_d;
      sweep_y_q <= sweep_y_d;
      ptr_q     <= ptr_next;
      x         <= x_d;
      y         <= y_d;
      colour    <= colour_d;
      plot      <= plot_d;
    end
  end

`ifdef PLOT_ARBITER_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      drop_count    <= '0;
      overrun_count <= '0;
    end else begin
      if (transfer && !in_range && (drop_count != '1))
        drop_count <= drop_count + 1'b1;
      if (frame_tick && (state_q == CLEAR) && (overrun_count != '1))
        overrun_count <= overrun_count + 1'b1;
    end
  end
`endif

endmodule
